// File: rtl/branch_update_ctrl.sv
// Resolved-branch update controller: queues resolved branches from execute,
// drains them into the branch table and flags mispredicts with a fetch redirect.
module branch_update_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_hit,
  input  logic        ex_pred,
  input  logic        hold,
  output logic        write_rt,
  output logic        write_rp,
  output logic [31:0] instruction_update,
  output logic [31:0] b_dest_in,
  output logic        result_alu,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [15:0] mispredict_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            redirect_q, redirect_d;
  logic [31:0]     redirect_pc_q, redirect_pc_d;
  logic [15:0]     mis_cnt_q, mis_cnt_d;

  logic [31:0]     pc_mem_q     [DEPTH];
  logic [31:0]     target_mem_q [DEPTH];
  logic            taken_mem_q  [DEPTH];
  logic            hit_mem_q    [DEPTH];

  logic            accept_s;
  logic            pop_s;
  logic            eff_pred_s;
  logic            mispredict_s;

  // ready comes from registered occupancy only, so a pop never opens a slot in the same cycle
  assign ex_ready     = (count_q < CW'(DEPTH));
  assign accept_s     = ex_valid && ex_ready;
  assign pop_s        = (state_q == ST_WRITE) && (count_q != {CW{1'b0}});
  assign eff_pred_s   = ex_hit ? ex_pred : 1'b0;
  assign mispredict_s = accept_s && (eff_pred_s != ex_taken);

  // Queue bookkeeping and mispredict tracking next-state logic
  always_comb begin
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    redirect_d    = mispredict_s;
    redirect_pc_d = redirect_pc_q;
    mis_cnt_d     = mis_cnt_q;
    case ({accept_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (accept_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (mispredict_s) begin
      redirect_pc_d = ex_taken ? ex_target : (ex_pc + 32'd4);
      mis_cnt_d     = (mis_cnt_q == 16'hFFFF) ? mis_cnt_q : (mis_cnt_q + 16'd1);
    end else begin
      redirect_pc_d = redirect_pc_q;
      mis_cnt_d     = mis_cnt_q;
    end
  end

  // Drain FSM next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (hold) begin
          state_d = ST_HOLD;
        end else if (count_q != {CW{1'b0}}) begin
          state_d = ST_WRITE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (hold) begin
          state_d = ST_HOLD;
        end else if (count_d != {CW{1'b0}}) begin
          state_d = ST_WRITE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (hold) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Table strobes: hit refreshes prediction only, taken miss allocates, untaken miss is dropped
  always_comb begin
    write_rt = 1'b0;
    write_rp = 1'b0;
    if (pop_s) begin
      if (hit_mem_q[rd_ptr_q]) begin
        write_rp = 1'b1;
      end else if (taken_mem_q[rd_ptr_q]) begin
        write_rt = 1'b1;
        write_rp = 1'b1;
      end else begin
        write_rt = 1'b0;
        write_rp = 1'b0;
      end
    end else begin
      write_rt = 1'b0;
      write_rp = 1'b0;
    end
  end

  assign instruction_update = pc_mem_q[rd_ptr_q];
  assign b_dest_in          = target_mem_q[rd_ptr_q];
  assign result_alu         = taken_mem_q[rd_ptr_q];
  assign redirect           = redirect_q;
  assign redirect_pc        = redirect_pc_q;
  assign mispredict_cnt     = mis_cnt_q;

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      count_q       <= {CW{1'b0}};
      wr_ptr_q      <= {PW{1'b0}};
      rd_ptr_q      <= {PW{1'b0}};
      redirect_q    <= 1'b0;
      redirect_pc_q <= 32'd0;
      mis_cnt_q     <= 16'd0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      mis_cnt_q     <= mis_cnt_d;
    end
  end

  // Entry storage; contents are meaningless until counted, so no reset is needed
  always_ff @(posedge clk) begin
    if (accept_s) begin
      pc_mem_q[wr_ptr_q]     <= ex_pc;
      target_mem_q[wr_ptr_q] <= ex_target;
      taken_mem_q[wr_ptr_q]  <= ex_taken;
      hit_mem_q[wr_ptr_q]    <= ex_hit;
    end
  end

endmodule

// File: doc/branch_update_ctrl.md
BRANCH_UPDATE_CTRL -- requirements
Module: branch_update_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning number of entries in the resolved-branch queue (power of two, 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port ex_valid, input, 1 bit: a resolved branch is offered this cycle.
REQ-005 The block SHALL have port ex_ready, output, 1 bit: the queue can accept the offered branch.
REQ-006 The block SHALL have port ex_pc, input, 32 bits: the branch address, used as the branch table key.
REQ-007 The block SHALL have port ex_taken, input, 1 bit: the actual outcome.
REQ-008 The block SHALL have port ex_target, input, 32 bits: the computed taken destination.
REQ-009 The block SHALL have port ex_hit, input, 1 bit: the table hit carried from fetch.
REQ-010 The block SHALL have port ex_pred, input, 1 bit: the prediction carried from fetch.
REQ-011 The block SHALL have port hold, input, 1 bit: freeze table writes (debug or table reload).
REQ-012 The block SHALL have port write_rt, output, 1 bit: tag/destination write strobe to the table.
REQ-013 The block SHALL have port write_rp, output, 1 bit: prediction write strobe to the table.
REQ-014 The block SHALL have port instruction_update, output, 32 bits: the key for the table write.
REQ-015 The block SHALL have port b_dest_in, output, 32 bits: the destination written to the table.
REQ-016 The block SHALL have port result_alu, output, 1 bit: the prediction bit written to the table.
REQ-017 The block SHALL have port redirect, output, 1 bit: a one-cycle fetch redirect pulse on mispredict.
REQ-018 The block SHALL have port redirect_pc, output, 32 bits: the correct next fetch address.
REQ-019 The block SHALL have port mispredict_cnt, output, 16 bits: the saturating mispredict count.

Function
REQ-020 The block SHALL drive ex_ready = (count < DEPTH); ex_ready SHALL depend only on registered state.
REQ-021 The block SHALL perform an accept when ex_valid && ex_ready, storing {pc, taken, target, hit} at the write pointer.
REQ-022 The block SHALL treat ex_valid && !ex_ready as a stall: no state change, no redirect, and the offer remains on the inputs.
REQ-023 The block SHALL compute effective prediction = ex_hit ? ex_pred : 0 (a miss predicts not-taken).
REQ-024 The block SHALL register mispredict = accept && (effective prediction != ex_taken), so that redirect is asserted in the cycle after the accept, for exactly 1 cycle.
REQ-025 The block SHALL set redirect_pc = ex_taken ? ex_target : ex_pc + 4, registered in the same cycle as redirect; redirect_pc SHALL hold its value otherwise.
REQ-026 The block SHALL increment mispredict_cnt on each mispredict and saturate it at 16'hFFFF.
REQ-027 The drain FSM SHALL have states IDLE, WRITE and HOLD.
REQ-028 In IDLE, when the queue is non-empty and hold=0, the FSM SHALL go to WRITE; when hold=1, it SHALL go to HOLD.
REQ-029 In WRITE, the block SHALL pop the head and issue its strobes in this cycle.
REQ-030 From WRITE, the FSM SHALL stay in WRITE if entries remain and hold=0, go to HOLD if hold=1, and otherwise go to IDLE; throughput is 1 update/cycle.
REQ-031 In HOLD, no strobes SHALL be issued; the FSM SHALL return to IDLE when hold=0, and accepts SHALL continue until full.
REQ-032 The block SHALL generate the strobes for a popped entry as follows: hit -> write_rp=1, write_rt=0; miss and taken -> write_rt=1, write_rp=1; miss and not-taken -> no strobes (entry discarded).
REQ-033 The block SHALL drive instruction_update, b_dest_in and result_alu from the popped entry; they are don't-care when no strobe is active.
REQ-034 The strobes SHALL be combinational from the registered FSM state and queue head, and SHALL never be asserted outside WRITE.
REQ-035 On simultaneous accept and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-036 The pointers SHALL wrap modulo DEPTH.
REQ-037 A full queue with a pop in the same cycle SHALL not accept in that cycle, because ex_ready is registered-based.
REQ-038 A branch accepted in cycle N SHALL be eligible to pop no earlier than cycle N+1.

Reset
REQ-039 When rst_n=0, the block SHALL asynchronously clear the state to IDLE, count, pointers, redirect, redirect_pc and mispredict_cnt to 0; ex_ready SHALL be 1 and the strobes 0.
REQ-040 Reset during WRITE SHALL abort the write: the strobes drop immediately and queued entries are lost.
REQ-041 Release of reset SHALL be synchronous to clk.

Verification
REQ-042 The bench SHALL cover: accept pc=0x40, hit=1, pred=1, taken=0 -> next cycle redirect=1, redirect_pc=0x44, mispredict_cnt=1; following cycle write_rp=1, result_alu=0, write_rt=0.
REQ-043 The bench SHALL cover: accept pc=0x80, hit=0, taken=1, target=0x200 -> redirect_pc=0x200; write_rt=write_rp=1, instruction_update=0x80, b_dest_in=0x200.
REQ-044 The bench SHALL cover: accept pc=0xC0, hit=0, taken=0 -> no redirect, no strobes, count returns to 0.
REQ-045 The bench SHALL cover: hold=1 with 4 accepts -> ex_ready=0 after the 4th; 5th offer stalled; release hold -> 4 consecutive WRITE cycles in FIFO order.
REQ-046 The bench SHALL cover: 65536 mispredicts -> mispredict_cnt stays at 16'hFFFF.
REQ-047 The bench SHALL cover: rst_n low mid-drain with 3 entries -> strobes low at once, count=0, ex_ready=1.
